multicycle_ctrl: RTL and testbench

Parametrised multicycle control unit for the RV32 datapath. It drives the PC, IR, A/B, ALUOut and MDR register enables, the ALU and writeback muxes, and the memory strobes. Unlike the previous fixed-latency unit, it handshakes with variable-latency instruction and data memories, times out stalled accesses, and raises precise traps with a cause code. It sits between the IR and every datapath load/select input.

---
 rtl/multicycle_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control unit for the RV32 datapath.
// Handshakes with variable-latency instruction/data memories, times out
// stalled accesses and raises precise traps with a registered cause code.
// Optional feature macro: MULTICYCLE_CTRL_SHIFT_EN (builds the SHIFT state
// for slli/srli/srai; without it those encodings trap as illegal).
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned CAUSE_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr,
    input  logic               mem_ready,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               dmem_write,
    output logic [1:0]         size,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_funct,
    output logic               load_ir,
    output logic               load_a,
    output logic               load_b,
    output logic               load_alu_out,
    output logic               load_mdr,
    output logic               reg_write,
    output logic [2:0]         mem_to_reg,
    output logic [1:0]         branch_op,
    output logic [1:0]         shift_ctrl,
    output logic               epc_write,
    output logic               cause_write,
    output logic [CAUSE_W-1:0] cause,
    output logic               halted,
    output logic [4:0]         state
);

    typedef enum logic [4:0] {
        StIdle    = 5'd0,
        StFetch   = 5'd1,
        StDecode  = 5'd2,
        StExecR   = 5'd3,
        StAddr    = 5'd4,
        StMemRd   = 5'd5,
        StMemWr   = 5'd6,
        StWbAlu   = 5'd7,
        StWbMem   = 5'd8,
        StWbLui   = 5'd9,
`ifdef MULTICYCLE_CTRL_SHIFT_EN
        StShift   = 5'd10,
`endif
        StSlt     = 5'd11,
        StBranch  = 5'd12,
        StLink    = 5'd13,
        StJalrTgt = 5'd14,
        StJump    = 5'd15,
        StTrap    = 5'd16,
        StHalt    = 5'd17
    } state_e;

    localparam logic [CAUSE_W-1:0] CauseFetch   = CAUSE_W'(1);
    localparam logic [CAUSE_W-1:0] CauseIllegal = CAUSE_W'(2);
    localparam logic [CAUSE_W-1:0] CauseHalt    = CAUSE_W'(3);
    localparam logic [CAUSE_W-1:0] CauseLoad    = CAUSE_W'(5);
    localparam logic [CAUSE_W-1:0] CauseStore   = CAUSE_W'(7);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBeq    = 7'b1100011;
    localparam logic [6:0] OpBrJalr = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    state_e             r_state;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CAUSE_W-1:0] r_cause;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rd;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_rd     = instr[11:7];

    logic w_is_add, w_is_sub, w_is_and, w_is_slt, w_is_r_alu;
    logic w_is_addi, w_is_slti, w_is_slli, w_is_srli, w_is_srai, w_is_shift;
    logic w_is_lw, w_is_sw, w_is_lui, w_is_beq, w_is_bxx, w_is_jal, w_is_jalr;
    logic w_is_ebreak;

    assign w_is_add    = (w_opcode == OpR) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0000000);
    assign w_is_sub    = (w_opcode == OpR) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0100000);
    assign w_is_and    = (w_opcode == OpR) && (w_funct3 == 3'b111) && (w_funct7 == 7'b0000000);
    assign w_is_slt    = (w_opcode == OpR) && (w_funct3 == 3'b010) && (w_funct7 == 7'b0000000);
    assign w_is_r_alu  = w_is_add || w_is_sub || w_is_and;

    assign w_is_addi   = (w_opcode == OpImm) && (w_funct3 == 3'b000);
    assign w_is_slti   = (w_opcode == OpImm) && (w_funct3 == 3'b010);
    assign w_is_slli   = (w_opcode == OpImm) && (w_funct3 == 3'b001) && (w_funct7 == 7'b0000000);
    assign w_is_srli   = (w_opcode == OpImm) && (w_funct3 == 3'b101) && (w_funct7 == 7'b0000000);
    assign w_is_srai   = (w_opcode == OpImm) && (w_funct3 == 3'b101) && (w_funct7 == 7'b0100000);
    assign w_is_shift  = w_is_slli || w_is_srli || w_is_srai;

    assign w_is_lw     = (w_opcode == OpLoad) && (w_funct3 == 3'b010);
    assign w_is_sw     = (w_opcode == OpStore) && (w_funct3 == 3'b010);
    assign w_is_lui    = (w_opcode == OpLui);
    assign w_is_beq    = (w_opcode == OpBeq) && (w_funct3 == 3'b000);
    // bne/blt/bge share the jalr major opcode; funct3 = 000 is jalr.
    assign w_is_bxx    = (w_opcode == OpBrJalr) &&
                         ((w_funct3 == 3'b001) || (w_funct3 == 3'b100) || (w_funct3 == 3'b101));
    assign w_is_jal    = (w_opcode == OpJal);
    assign w_is_jalr   = (w_opcode == OpBrJalr) && (w_funct3 == 3'b000);
    assign w_is_ebreak = (instr == 32'h0010_0073);

    logic w_timeout;
    assign w_timeout = (r_wait_cnt == CNT_W'(MEM_TIMEOUT));

    state_e w_dispatch;

    // DECODE dispatch target for the instruction held in IR.
    always_comb begin
        w_dispatch = StTrap;
        if (w_is_r_alu) begin
            w_dispatch = StExecR;
        end else if (w_is_slt || w_is_slti) begin
            w_dispatch = StSlt;
        end else if (w_is_addi && (w_rd == 5'd0)) begin
            w_dispatch = StFetch;
        end else if (w_is_addi || w_is_lw || w_is_sw) begin
            w_dispatch = StAddr;
        end else if (w_is_shift) begin
`ifdef MULTICYCLE_CTRL_SHIFT_EN
            w_dispatch = StShift;
`else
            w_dispatch = StTrap;
`endif
        end else if (w_is_lui) begin
            w_dispatch = StWbLui;
        end else if (w_is_beq || w_is_bxx) begin
            w_dispatch = StBranch;
        end else if (w_is_jal || w_is_jalr) begin
            w_dispatch = StLink;
        end else if (w_is_ebreak) begin
            w_dispatch = StHalt;
        end
    end

    // State, memory wait counter and trap cause register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_wait_cnt <= '0;
            r_cause    <= '0;
        end else begin
            // Counter is zero outside a stalled access, so every entry to a
            // memory state starts from zero.
            r_wait_cnt <= '0;
            unique case (r_state)
                StIdle: r_state <= StFetch;
                StFetch: begin
                    if (mem_ready) begin
                        r_state <= StDecode;
                    end else if (w_timeout) begin
                        r_state <= StTrap;
                        r_cause <= CauseFetch;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                StDecode: begin
                    r_state <= w_dispatch;
                    if (w_dispatch == StTrap) begin
                        r_cause <= CauseIllegal;
                    end else if (w_dispatch == StHalt) begin
                        r_cause <= CauseHalt;
                    end
                end
                StExecR: r_state <= StWbAlu;
                StAddr: begin
                    if (w_is_lw) begin
                        r_state <= StMemRd;
                    end else if (w_is_sw) begin
                        r_state <= StMemWr;
                    end else begin
                        r_state <= StWbAlu;
                    end
                end
                StMemRd: begin
                    if (mem_ready) begin
                        r_state <= StWbMem;
                    end else if (w_timeout) begin
                        r_state <= StTrap;
                        r_cause <= CauseLoad;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                StMemWr: begin
                    if (mem_ready) begin
                        r_state <= StFetch;
                    end else if (w_timeout) begin
                        r_state <= StTrap;
                        r_cause <= CauseStore;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                StWbAlu, StWbMem, StWbLui, StSlt, StBranch, StJump, StTrap: begin
                    r_state <= StFetch;
                end
`ifdef MULTICYCLE_CTRL_SHIFT_EN
                StShift: r_state <= StFetch;
`endif
                StLink:    r_state <= w_is_jalr ? StJalrTgt : StJump;
                StJalrTgt: r_state <= StJump;
                StHalt:    r_state <= StHalt;
                default:   r_state <= StIdle;
            endcase
        end
    end

    // Moore output decode; only the FETCH/MEM_RD load enables see mem_ready.
    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_write    = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_funct     = 3'b000;
        load_ir       = 1'b0;
        load_a        = 1'b0;
        load_b        = 1'b0;
        load_alu_out  = 1'b0;
        load_mdr      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 3'd0;
        branch_op     = 2'b00;
        shift_ctrl    = 2'b00;
        epc_write     = 1'b0;
        cause_write   = 1'b0;
        halted        = 1'b0;
        unique case (r_state)
            StFetch: begin
                imem_req  = 1'b1;
                alu_src_b = 2'd1;
                alu_funct = 3'b001;
                load_ir   = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: begin
                load_a       = 1'b1;
                load_b       = 1'b1;
                load_alu_out = 1'b1;
                alu_src_b    = 2'd3;
                alu_funct    = 3'b001;
            end
            StExecR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'd0;
                alu_funct    = w_is_sub ? 3'b010 : (w_is_and ? 3'b011 : 3'b001);
                load_alu_out = 1'b1;
            end
            StAddr, StJalrTgt: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'd2;
                alu_funct    = 3'b001;
                load_alu_out = 1'b1;
            end
            StMemRd: begin
                dmem_req = 1'b1;
                load_mdr = mem_ready;
            end
            StMemWr: begin
                dmem_req   = 1'b1;
                dmem_write = 1'b1;
            end
            StWbAlu: begin
                reg_write  = 1'b1;
                mem_to_reg = 3'd0;
            end
            StWbMem: begin
                reg_write  = 1'b1;
                mem_to_reg = 3'd1;
            end
            StWbLui: begin
                reg_write  = 1'b1;
                mem_to_reg = 3'd2;
            end
`ifdef MULTICYCLE_CTRL_SHIFT_EN
            StShift: begin
                reg_write  = 1'b1;
                mem_to_reg = 3'd4;
                shift_ctrl = w_is_srai ? 2'b10 : (w_is_srli ? 2'b01 : 2'b00);
            end
`endif
            StSlt: begin
                reg_write  = 1'b1;
                mem_to_reg = 3'd5;
                alu_funct  = 3'b010;
                alu_src_b  = w_is_slti ? 2'd2 : 2'd0;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'd0;
                alu_funct     = 3'b010;
                pc_write_cond = 1'b1;
                pc_src        = 2'd1;
                if (w_opcode == OpBrJalr) begin
                    unique case (w_funct3)
                        3'b001:  branch_op = 2'b01;
                        3'b101:  branch_op = 2'b10;
                        3'b100:  branch_op = 2'b11;
                        default: branch_op = 2'b00;
                    endcase
                end
            end
            StLink: begin
                reg_write  = 1'b1;
                mem_to_reg = 3'd3;
            end
            StJump: begin
                pc_write = 1'b1;
                pc_src   = 2'd1;
            end
            StTrap: begin
                epc_write   = 1'b1;
                cause_write = 1'b1;
                pc_write    = 1'b1;
                pc_src      = 2'd2;
            end
            StHalt: halted = 1'b1;
            default: ;
        endcase
    end

    assign size  = 2'b00;
    assign cause = r_cause;
    assign state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. The driver walks an instruction-level
// reference model (state path per instruction class, wait/timeout rules) and
// queues one expected record per cycle; the monitor checks every cycle.
module tb_multicycle_ctrl;

    localparam int unsigned MEM_TIMEOUT = 15;

    localparam logic [4:0] S_IDLE = 5'd0, S_FETCH = 5'd1, S_DECODE = 5'd2, S_EXEC_R = 5'd3;
    localparam logic [4:0] S_ADDR = 5'd4, S_MEM_RD = 5'd5, S_MEM_WR = 5'd6, S_WB_ALU = 5'd7;
    localparam logic [4:0] S_WB_MEM = 5'd8, S_WB_LUI = 5'd9, S_SHIFT = 5'd10, S_SLT = 5'd11;
    localparam logic [4:0] S_BRANCH = 5'd12, S_LINK = 5'd13, S_JALR_TGT = 5'd14;
    localparam logic [4:0] S_JUMP = 5'd15, S_TRAP = 5'd16, S_HALT = 5'd17;

    typedef enum int {
        KAdd, KSub, KAnd, KSlt, KAddi, KNop, KSlti, KLw, KSw, KSlli, KSrli, KSrai,
        KLui, KBeq, KBne, KBge, KBlt, KJal, KJalr, KEbreak, KIllegal
    } kind_e;

    typedef struct {
        logic       rdy;
        logic [4:0] st;
        kind_e      kind;
        logic [3:0] cause;
    } rec_t;

    logic        clk, rst_n, mem_ready;
    logic [31:0] instr;
    logic        imem_req, dmem_req, dmem_write, pc_write, pc_write_cond, alu_src_a;
    logic        load_ir, load_a, load_b, load_alu_out, load_mdr, reg_write;
    logic        epc_write, cause_write, halted;
    logic [1:0]  size, pc_src, alu_src_b, branch_op, shift_ctrl;
    logic [2:0]  alu_funct, mem_to_reg;
    logic [3:0]  cause;
    logic [4:0]  state;
    logic [34:0] dut_vec;

    multicycle_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (4),
        .CAUSE_W     (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .mem_ready     (mem_ready),
        .imem_req      (imem_req),
        .dmem_req      (dmem_req),
        .dmem_write    (dmem_write),
        .size          (size),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_funct     (alu_funct),
        .load_ir       (load_ir),
        .load_a        (load_a),
        .load_b        (load_b),
        .load_alu_out  (load_alu_out),
        .load_mdr      (load_mdr),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .branch_op     (branch_op),
        .shift_ctrl    (shift_ctrl),
        .epc_write     (epc_write),
        .cause_write   (cause_write),
        .cause         (cause),
        .halted        (halted),
        .state         (state)
    );

    assign dut_vec = {imem_req, dmem_req, dmem_write, size, pc_write, pc_write_cond, pc_src,
                      alu_src_a, alu_src_b, alu_funct, load_ir, load_a, load_b, load_alu_out,
                      load_mdr, reg_write, mem_to_reg, branch_op, shift_ctrl, epc_write,
                      cause_write, cause, halted};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    rec_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  cause_m;
    kind_e       cur_kind;
    logic [31:0] cur_instr;

    // Expected control outputs for one cycle, straight from the state table.
    function automatic logic [34:0] exp_vec(input rec_t r);
        logic       imr, dmr, dmw, pcw, pcwc, asa, lir, la, lb, lao, lmdr, rw, epcw, cw, hlt;
        logic [1:0] pcs, asb, bop, shc;
        logic [2:0] fn, m2r;
        {imr, dmr, dmw, pcw, pcwc, asa, lir, la, lb, lao, lmdr, rw, epcw, cw, hlt} = '0;
        {pcs, asb, bop, shc, fn, m2r} = '0;
        case (r.st)
            S_FETCH:    begin imr = 1; asb = 1; fn = 1; lir = r.rdy; pcw = r.rdy; end
            S_DECODE:   begin la = 1; lb = 1; lao = 1; asb = 3; fn = 1; end
            S_EXEC_R: begin
                asa = 1; lao = 1;
                fn = (r.kind == KSub) ? 3'd2 : ((r.kind == KAnd) ? 3'd3 : 3'd1);
            end
            S_ADDR:     begin asa = 1; asb = 2; fn = 1; lao = 1; end
            S_MEM_RD:   begin dmr = 1; lmdr = r.rdy; end
            S_MEM_WR:   begin dmr = 1; dmw = 1; end
            S_WB_ALU:   begin rw = 1; m2r = 0; end
            S_WB_MEM:   begin rw = 1; m2r = 1; end
            S_WB_LUI:   begin rw = 1; m2r = 2; end
            S_SHIFT: begin
                rw = 1; m2r = 4;
                shc = (r.kind == KSrai) ? 2'b10 : ((r.kind == KSrli) ? 2'b01 : 2'b00);
            end
            S_SLT:      begin rw = 1; m2r = 5; fn = 2; asb = (r.kind == KSlti) ? 2'd2 : 2'd0; end
            S_BRANCH: begin
                asa = 1; fn = 2; pcwc = 1; pcs = 1;
                case (r.kind)
                    KBne:    bop = 2'b01;
                    KBge:    bop = 2'b10;
                    KBlt:    bop = 2'b11;
                    default: bop = 2'b00;
                endcase
            end
            S_LINK:     begin rw = 1; m2r = 3; end
            S_JALR_TGT: begin asa = 1; asb = 2; fn = 1; lao = 1; end
            S_JUMP:     begin pcw = 1; pcs = 1; end
            S_TRAP:     begin epcw = 1; cw = 1; pcw = 1; pcs = 2; end
            S_HALT:     hlt = 1;
            default: ;
        endcase
        return {imr, dmr, dmw, 2'b00, pcw, pcwc, pcs, asa, asb, fn, lir, la, lb, lao, lmdr,
                rw, m2r, bop, shc, epcw, cw, r.cause, hlt};
    endfunction

    // Random encoding of an instruction of the requested class.
    function automatic logic [31:0] rand_word(input kind_e k);
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [19:0] imm20;
        logic [31:0] w;
        rd    = 5'($urandom_range(1, 31));
        rs1   = 5'($urandom);
        rs2   = 5'($urandom);
        imm   = 12'($urandom);
        imm20 = 20'($urandom);
        case (k)
            KAdd:   w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            KSub:   w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            KAnd:   w = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
            KSlt:   w = {7'b0000000, rs2, rs1, 3'b010, rd, 7'b0110011};
            KAddi:  w = {imm, rs1, 3'b000, rd, 7'b0010011};
            KNop:   w = {imm, rs1, 3'b000, 5'd0, 7'b0010011};
            KSlti:  w = {imm, rs1, 3'b010, rd, 7'b0010011};
            KLw:    w = {imm, rs1, 3'b010, rd, 7'b0000011};
            KSw:    w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            KSlli:  w = {7'b0000000, rs2, rs1, 3'b001, rd, 7'b0010011};
            KSrli:  w = {7'b0000000, rs2, rs1, 3'b101, rd, 7'b0010011};
            KSrai:  w = {7'b0100000, rs2, rs1, 3'b101, rd, 7'b0010011};
            KLui:   w = {imm20, rd, 7'b0110111};
            KBeq:   w = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b1100011};
            KBne:   w = {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b1100111};
            KBge:   w = {imm[11:5], rs2, rs1, 3'b101, imm[4:0], 7'b1100111};
            KBlt:   w = {imm[11:5], rs2, rs1, 3'b100, imm[4:0], 7'b1100111};
            KJal:   w = {imm20, rd, 7'b1101111};
            KJalr:  w = {imm, rs1, 3'b000, rd, 7'b1100111};
            KEbreak: w = 32'h0010_0073;
            default: begin
                case ($urandom_range(0, 4))
                    0:       w = 32'hFFFF_FFFF;
                    1:       w = 32'h0000_0000;
                    2:       w = {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
                    3:       w = {7'b0000000, rs2, rs1, 3'b001, rd, 7'b0110011};
                    default: w = {imm, rs1, 3'b010, rd, 7'b1100111};
                endcase
            end
        endcase
        return w;
    endfunction

    function automatic int pick_wait();
        case ($urandom_range(0, 9))
            5:       return 1;
            6:       return int'($urandom_range(2, 4));
            7:       return int'(MEM_TIMEOUT);
            8:       return int'(MEM_TIMEOUT) + 1;
            default: return 0;
        endcase
    endfunction

    // Drive this cycle's inputs and queue the expected record.
    task automatic apply(input logic rdy, input logic [4:0] st);
        rec_t r;
        mem_ready = rdy;
        instr     = cur_instr;
        r.rdy     = rdy;
        r.st      = st;
        r.kind    = cur_kind;
        r.cause   = cause_m;
        q.push_back(r);
    endtask

    task automatic step(input logic rdy, input logic [4:0] st);
        @(negedge clk);
        apply(rdy, st);
    endtask

    // mem_ready is a don't-care outside memory states, so randomise it there.
    task automatic step_any(input logic [4:0] st);
        step(1'($urandom_range(0, 1)), st);
    endtask

    // One memory access: waits beyond MEM_TIMEOUT end in a trap.
    task automatic mem_access(input logic [4:0] st, input int waits, input logic [3:0] fault,
                              output logic ok);
        if (waits > int'(MEM_TIMEOUT)) begin
            for (int i = 0; i <= int'(MEM_TIMEOUT); i++) step(1'b0, st);
            cause_m = fault;
            step_any(S_TRAP);
            ok = 1'b0;
        end else begin
            for (int i = 0; i < waits; i++) step(1'b0, st);
            step(1'b1, st);
            ok = 1'b1;
        end
    endtask

    task automatic run_instr(input kind_e k, input logic [31:0] w, input int fw, input int dw,
                             input int halt_n);
        logic ok;
        cur_kind  = k;
        cur_instr = w;
        mem_access(S_FETCH, fw, 4'd1, ok);
        if (ok) begin
            step_any(S_DECODE);
            case (k)
                KAdd, KSub, KAnd: begin step_any(S_EXEC_R); step_any(S_WB_ALU); end
                KSlt, KSlti:      step_any(S_SLT);
                KAddi:            begin step_any(S_ADDR); step_any(S_WB_ALU); end
                KNop:             ;
                KLw: begin
                    step_any(S_ADDR);
                    mem_access(S_MEM_RD, dw, 4'd5, ok);
                    if (ok) step_any(S_WB_MEM);
                end
                KSw: begin
                    step_any(S_ADDR);
                    mem_access(S_MEM_WR, dw, 4'd7, ok);
                end
                KSlli, KSrli, KSrai: begin
`ifdef MULTICYCLE_CTRL_SHIFT_EN
                    step_any(S_SHIFT);
`else
                    cause_m = 4'd2;
                    step_any(S_TRAP);
`endif
                end
                KLui:                   step_any(S_WB_LUI);
                KBeq, KBne, KBge, KBlt: step_any(S_BRANCH);
                KJal:                   begin step_any(S_LINK); step_any(S_JUMP); end
                KJalr: begin step_any(S_LINK); step_any(S_JALR_TGT); step_any(S_JUMP); end
                KEbreak: begin
                    cause_m = 4'd3;
                    repeat (halt_n) step_any(S_HALT);
                end
                default: begin
                    cause_m = 4'd2;
                    step_any(S_TRAP);
                end
            endcase
        end
    endtask

    // Reset asserted between clock edges; outputs must clear immediately.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n    = 1'b0;
        cause_m  = 4'd0;
        cur_kind = KNop;
        apply(1'b0, S_IDLE);
        repeat (cycles - 1) step_any(S_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'($urandom_range(0, 1)), S_IDLE);
    endtask

    // Monitor: one queued record per cycle, compared mid-low-phase.
    initial begin : monitor
        rec_t        r;
        logic [34:0] ev;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                r  = q.pop_front();
                ev = exp_vec(r);
                checks++;
                if (state !== r.st || dut_vec !== ev) begin
                    errors++;
                    $display("FAIL cycle t=%0t: got state=%0d outs=%h, expected state=%0d outs=%h",
                             $time, state, dut_vec, r.st, ev);
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        kind_e k;
        int    sel;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        instr     = '0;
        cur_instr = '0;
        cause_m   = 4'd0;
        cur_kind  = KNop;
        do_reset(3);

        // Directed cases.
        run_instr(KAdd, 32'h0020_81B3, 0, 0, 0);
        run_instr(KLw, rand_word(KLw), 0, 3, 0);
        run_instr(KAdd, 32'h0020_81B3, int'(MEM_TIMEOUT) + 1, 0, 0);
        run_instr(KAdd, 32'h0020_81B3, int'(MEM_TIMEOUT), 0, 0);
        run_instr(KIllegal, 32'hFFFF_FFFF, 0, 0, 0);
        run_instr(KSlli, rand_word(KSlli), 0, 0, 0);
        run_instr(KSw, rand_word(KSw), 1, int'(MEM_TIMEOUT) + 1, 0);
        run_instr(KLw, rand_word(KLw), 0, int'(MEM_TIMEOUT) + 1, 0);
        run_instr(KJalr, rand_word(KJalr), 0, 0, 0);
        run_instr(KNop, rand_word(KNop), 0, 0, 0);
        run_instr(KEbreak, 32'h0010_0073, 0, 0, 100);
        do_reset(2);

        // Reset in the middle of a stalled store.
        cur_kind  = KSw;
        cur_instr = rand_word(KSw);
        step(1'b1, S_FETCH);
        step_any(S_DECODE);
        step_any(S_ADDR);
        step(1'b0, S_MEM_WR);
        step(1'b0, S_MEM_WR);
        do_reset(2);

        // Random instruction stream.
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 44));
            if (sel < 38)      k = kind_e'(sel % 19);
            else if (sel < 44) k = KIllegal;
            else               k = KEbreak;
            run_instr(k, rand_word(k), pick_wait(), pick_wait(), 5);
            if (k == KEbreak) do_reset(2);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
